// File: rtl/crypto_wallet2_nios_fast_pi_button.sv
// Avalon-MM input PIO: synchronizes and debounces button/switch lines, captures
// edges into a W1C register and raises a maskable level interrupt.
module crypto_wallet2_nios_fast_pi_button #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            sync1_q, sync2_q;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]            stable_q, stable_d;
    logic [WIDTH-1:0]            prev_q;
    logic [WIDTH-1:0]            irqmask_q, irqmask_d;
    logic [WIDTH-1:0]            edgecap_q, edgecap_d;
    logic [31:0]                 readdata_q, readdata_d;
    logic                        irq_q, irq_d;

    logic [WIDTH-1:0] edge_c;
    logic [WIDTH-1:0] clr_c;
    logic             wr_c;
    logic             unused_wdata_c;

    assign wr_c           = chipselect && !write_n;
    assign unused_wdata_c = ^writedata;

    // Per-bit debounce: a differing level must hold DEBOUNCE_CYCLES cycles in a row.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_comb begin
        edge_c = '0;
        case (EDGE_TYPE)
            0:       edge_c = stable_q & ~prev_q;
            1:       edge_c = ~stable_q & prev_q;
            default: edge_c = stable_q ^ prev_q;
        endcase
    end

    // Register writes; a new edge wins over a simultaneous W1C clear.
    always_comb begin
        irqmask_d = irqmask_q;
        clr_c     = '0;
        if (wr_c && (address == 2'd2)) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_c && (address == 2'd3)) begin
            clr_c = writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~clr_c) | edge_c;
        irq_d     = |(edgecap_q & irqmask_q);
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d = 32'(stable_q);
            2'd2:    readdata_d = 32'(irqmask_q);
            2'd3:    readdata_d = 32'(edgecap_q);
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            cnt_q      <= '0;
            stable_q   <= '0;
            prev_q     <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            prev_q     <= stable_q;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
